// File: rtl/nn_argmax_classifier.sv
// -----------------------------------------------------------------------------
// nn_argmax_classifier
//
// Picks the winning class from the ten output-neuron scores of the 2-4-10
// network. After a start request the block waits SETTLE_CYCLES so that the
// network pipeline has settled. It then snapshots every score and scans the
// snapshot one class per cycle, tracking the best and second-best scores.
// The result is offered on a valid/ready handshake.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   scores_in    NUM_CLASSES signed scores, slot k at [k*WIDTH +: WIDTH]
//   start        classification request (taken when start && start_ready)
//   start_ready  high only while idle
//   out_valid    result valid (held until out_ready)
//   out_ready    downstream accepts the result
//   class_idx    0-based index of the winning slot
//   max_score    winning score
//   margin       max minus second-best, saturated, never negative
//   confident    max_score >= THRESH (signed)
//   busy         high whenever the block is not idle
// -----------------------------------------------------------------------------
module nn_argmax_classifier #(
    parameter int                      WIDTH         = 16,
    parameter int                      FRAC          = 8,
    parameter int                      NUM_CLASSES   = 10,
    parameter int                      SETTLE_CYCLES = 3,
    parameter logic signed [WIDTH-1:0] THRESH        = 16'sh00C0,
    parameter int                      IDX_W         = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CLASSES*WIDTH-1:0]   scores_in,
    input  logic                           start,
    output logic                           start_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_W-1:0]               class_idx,
    output logic [WIDTH-1:0]               max_score,
    output logic [WIDTH-1:0]               margin,
    output logic                           confident,
    output logic                           busy
);

    // Elaboration-time sanity checks on the parameter set.
    if (NUM_CLASSES < 1 || (2 ** IDX_W) < NUM_CLASSES) begin : g_bad_idx
        $error("nn_argmax_classifier: IDX_W too small for NUM_CLASSES");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("nn_argmax_classifier: SETTLE_CYCLES must be >= 1");
    end
    if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
        $error("nn_argmax_classifier: FRAC must lie inside WIDTH");
    end

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]        SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]        LAST_IDX    = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [WIDTH-1:0] MOST_NEG    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]        MAX_POS     = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SCAN   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                     state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [IDX_W-1:0]           idx_q;
    logic [IDX_W-1:0]           best_idx_q;
    logic [NUM_CLASSES*WIDTH-1:0] snap_q;
    logic signed [WIDTH-1:0]    best_q;
    logic signed [WIDTH-1:0]    second_q;

    logic                       start_ready_q;
    logic                       out_valid_q;
    logic                       busy_q;
    logic [IDX_W-1:0]           class_idx_q;
    logic [WIDTH-1:0]           max_score_q;
    logic [WIDTH-1:0]           margin_q;
    logic                       confident_q;

    // Scan datapath: one comparison of the current snapshot slot per cycle.
    logic signed [WIDTH-1:0]    cur;
    logic signed [WIDTH-1:0]    best_d;
    logic signed [WIDTH-1:0]    second_d;
    logic [IDX_W-1:0]           best_idx_d;
    logic signed [WIDTH:0]      diff;
    logic [WIDTH-1:0]           margin_d;
    logic                       confident_d;

    always_comb begin
        cur        = $signed(snap_q[int'(idx_q)*WIDTH +: WIDTH]);
        best_d     = best_q;
        second_d   = second_q;
        best_idx_d = best_idx_q;
        // Strict compare: an equal later score never displaces the earlier
        // winner, it only becomes the runner-up (margin 0).
        if (cur > best_q) begin
            second_d   = best_q;
            best_d     = cur;
            best_idx_d = idx_q;
        end else if (cur > second_q) begin
            second_d = cur;
        end
        // best_d >= second_d, so diff is non-negative; one extra bit covers
        // the full range (e.g. max positive minus most negative).
        diff = {best_d[WIDTH-1], best_d} - {second_d[WIDTH-1], second_d};
        if (diff > $signed({1'b0, MAX_POS})) begin
            margin_d = MAX_POS;
        end else begin
            margin_d = diff[WIDTH-1:0];
        end
        confident_d = (best_d >= THRESH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            best_idx_q    <= '0;
            snap_q        <= '0;
            best_q        <= '0;
            second_q      <= '0;
            start_ready_q <= 1'b1;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            class_idx_q   <= '0;
            max_score_q   <= '0;
            margin_q      <= '0;
            confident_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= SETTLE;
                        cnt_q         <= SETTLE_LOAD;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        // Only cycle in which scores_in is looked at.
                        snap_q     <= scores_in;
                        state_q    <= SCAN;
                        idx_q      <= '0;
                        best_q     <= MOST_NEG;
                        second_q   <= MOST_NEG;
                        best_idx_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                SCAN: begin
                    best_q     <= best_d;
                    second_q   <= second_d;
                    best_idx_q <= best_idx_d;
                    if (idx_q == LAST_IDX) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        class_idx_q <= best_idx_d;
                        max_score_q <= best_d;
                        margin_q    <= margin_d;
                        confident_q <= confident_d;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q       <= IDLE;
                        out_valid_q   <= 1'b0;
                        start_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign class_idx   = class_idx_q;
    assign max_score   = max_score_q;
    assign margin      = margin_q;
    assign confident   = confident_q;

endmodule

// File: tb/tb_nn_argmax_classifier.sv
// -----------------------------------------------------------------------------
// Bench for nn_argmax_classifier (default parameters). Expected results are
// computed from the bench's own copy of the scores and queued when a
// classification is launched; they are popped when out_valid appears.
// -----------------------------------------------------------------------------
module tb_nn_argmax_classifier;

    localparam int W = 16;
    localparam int N = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] scores_in;
    logic           start;
    logic           start_ready;
    logic           out_valid;
    logic           out_ready;
    logic [3:0]     class_idx;
    logic [W-1:0]   max_score;
    logic [W-1:0]   margin;
    logic           confident;
    logic           busy;

    nn_argmax_classifier dut (
        .clk         (clk),
        .rst         (rst),
        .scores_in   (scores_in),
        .start       (start),
        .start_ready (start_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .class_idx   (class_idx),
        .max_score   (max_score),
        .margin      (margin),
        .confident   (confident),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic [W-1:0] mx;
        logic [W-1:0] mg;
        logic         cf;
    } res_t;

    logic signed [W-1:0] sc [N];
    res_t                exp_q [$];
    int                  checks = 0;
    int                  errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) scores_in[i*W +: W] = sc[i];
    endtask

    // Reference: first index holding the maximum wins; runner-up is the
    // largest of all other slots; margin clipped to the positive range.
    function automatic res_t model();
        res_t r;
        int   b = 0;
        int   s = -100000;
        int   m;
        for (int i = 1; i < N; i++) if (int'(sc[i]) > int'(sc[b])) b = i;
        for (int j = 0; j < N; j++) if (j != b && int'(sc[j]) > s) s = int'(sc[j]);
        m = int'(sc[b]) - s;
        if (m > 32767) m = 32767;
        r.idx = 4'(b);
        r.mx  = sc[b];
        r.mg  = 16'(m);
        r.cf  = (int'(sc[b]) >= 192);
        return r;
    endfunction

    // Launch one classification, wait (bounded) for the result, compare it,
    // optionally stall in DONE, then release it with out_ready.
    task automatic do_run(input string tag, input bit corrupt, input int stall);
        res_t e;
        int   edges;
        apply();
        exp_q.push_back(model());
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_start_ready_lo"}, start_ready, 0);
        while (!out_valid && edges < 40) begin
            if (corrupt && edges == 6) begin
                for (int i = 0; i < N; i++) sc[i] = 16'sh0100;
                apply();
            end
            tick();
            edges++;
        end
        check({tag, "_latency"}, edges, 14);
        e = exp_q.pop_front();
        check({tag, "_class_idx"}, class_idx, e.idx);
        check({tag, "_max_score"}, max_score, e.mx);
        check({tag, "_margin"}, margin, e.mg);
        check({tag, "_confident"}, confident, e.cf);
        for (int k = 0; k < stall; k++) begin
            start = 1'b1;  // ignored while a result is pending
            tick();
            check({tag, "_stall_valid"}, out_valid, 1);
            check({tag, "_stall_idx"}, class_idx, e.idx);
            check({tag, "_stall_max"}, max_score, e.mx);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_start_ready_hi"}, start_ready, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) sc[i] = 16'($urandom);
        apply();
        tick();
        tick();
        check("rst_start_ready", start_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_class_idx", class_idx, 0);
        check("rst_max_score", max_score, 0);
        check("rst_margin", margin, 0);
        check("rst_confident", confident, 0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        // Basic: slot 6 is the clear winner.
        for (int i = 0; i < N; i++) sc[i] = 16'((i + 1) * 16);
        sc[6] = 16'sh00E6;
        do_run("basic", 1'b0, 0);

        // Tie between slots 2 and 7, below threshold.
        for (int i = 0; i < N; i++) sc[i] = 16'sh0040;
        sc[2] = 16'sh0080;
        sc[7] = 16'sh0080;
        do_run("tie", 1'b0, 0);

        // Winner exactly at threshold; scores overwritten mid-scan; stalled.
        for (int i = 0; i < N; i++) sc[i] = 16'(i * 17 - 48);
        sc[3] = 16'sh00C0;
        do_run("snap", 1'b1, 5);

        // Extremes: margin must saturate.
        for (int i = 0; i < N; i++) sc[i] = 16'sh8000;
        sc[0] = 16'sh7FFF;
        do_run("sat", 1'b0, 0);

        // Abort: second start in SETTLE ignored, reset during SCAN.
        for (int i = 0; i < N; i++) sc[i] = 16'($urandom);
        apply();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_start_ready", start_ready, 0);
        for (int k = 0; k < 5; k++) tick();
        check("abort_busy_scan", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_start_ready_hi", start_ready, 1);
        check("abort_class_idx", class_idx, 0);
        check("abort_max_score", max_score, 0);
        do_run("after_abort", 1'b0, 0);

        // A few random score sets.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) sc[i] = 16'($urandom_range(0, 511)) - 16'sd256;
            do_run("rand", 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
